pc_fetch_unit: RTL

- IF-stage front end that consumes the execute stage's redirect outputs: branch target and IF flush.
- Holds the PC and issues in-order instruction-memory requests over a valid/ready channel.
- Buffers returned instructions and presents them to the IF/ID register with a valid/ready handshake.
- Discards in-flight stale responses after a taken-branch redirect.

---
 rtl/pc_fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests under a
// credit limit, buffers returned words for IF/ID and squashes stale responses on redirect.
module pc_fetch_unit #(
   parameter int                         INST_ADDR_WIDTH = 32,
   parameter int                         INST_WIDTH      = 32,
   parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
   parameter int                         DEPTH           = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [INST_ADDR_WIDTH-1:0] redirect_addr,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                       imem_resp_valid,
   input  logic [INST_WIDTH-1:0]      imem_resp_data,
   output logic                       if_valid,
   input  logic                       if_ready,
   output logic [INST_WIDTH-1:0]      if_inst,
   output logic [INST_ADDR_WIDTH-1:0] if_inst_addr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [INST_ADDR_WIDTH-1:0] pc;
   logic [CW-1:0]              inflight;
   logic [CW-1:0]              drop_cnt;
   logic [CW-1:0]              buf_count;
   logic [PW-1:0]              af_wr, af_rd;
   logic [PW-1:0]              ib_wr, ib_rd;

   logic [INST_ADDR_WIDTH-1:0] af_mem  [DEPTH];
   logic [INST_WIDTH-1:0]      ib_inst [DEPTH];
   logic [INST_ADDR_WIDTH-1:0] ib_addr [DEPTH];

   logic [CW:0] credit_used;
   logic        req_fire;
   logic        resp_keep;
   logic        pop;

   // inflight counts responses still owed, including those already marked for drop
   assign credit_used    = {1'b0, inflight} + {1'b0, buf_count};
   assign imem_req_valid = !rst && !redirect && (credit_used < DEPTH_C);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_keep      = imem_resp_valid && (drop_cnt == '0) && !redirect;

   assign if_valid       = !rst && !redirect && (buf_count != '0);
   assign if_inst        = rst ? '0 : ib_inst[ib_rd];
   assign if_inst_addr   = rst ? '0 : ib_addr[ib_rd];
   assign pop            = if_valid && if_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         inflight  <= '0;
         drop_cnt  <= '0;
         buf_count <= '0;
         af_wr     <= '0;
         af_rd     <= '0;
         ib_wr     <= '0;
         ib_rd     <= '0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
         if (redirect) begin
            // everything still owed by memory belongs to the old path
            pc        <= {redirect_addr[INST_ADDR_WIDTH-1:2], 2'b00};
            drop_cnt  <= inflight - CW'(imem_resp_valid);
            buf_count <= '0;
            af_wr     <= '0;
            af_rd     <= '0;
            ib_wr     <= '0;
            ib_rd     <= '0;
         end else begin
            if (req_fire) begin
               pc    <= pc + INST_ADDR_WIDTH'(4);
               af_wr <= af_wr + PW'(1);
            end
            if (imem_resp_valid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CW'(1);
            if (resp_keep) begin
               af_rd <= af_rd + PW'(1);
               ib_wr <= ib_wr + PW'(1);
            end
            if (pop)
               ib_rd <= ib_rd + PW'(1);
            buf_count <= buf_count + CW'(resp_keep) - CW'(pop);
         end
      end
   end

   // storage needs no reset: occupancy is tracked by the pointers and counters above
   always_ff @(posedge clk) begin
      if (req_fire)
         af_mem[af_wr] <= pc;
      if (resp_keep) begin
         ib_inst[ib_wr] <= imem_resp_data;
         ib_addr[ib_wr] <= af_mem[af_rd];
      end
   end

   resp_needs_request: assert property (@(posedge clk) disable iff (rst)
      !(imem_resp_valid && (inflight == '0)));

   credit_bound: assert property (@(posedge clk) disable iff (rst)
      credit_used <= DEPTH_C);

endmodule
